// File: rtl/mcu_link_pkg.sv
// mcu_link_pkg: frame layouts, FSM states and MOSI frame validation shared by the MCU link slave
package mcu_link_pkg;
   localparam int FRAME_BITS = 16;
   localparam int CNT_W = 5;
   localparam logic [CNT_W-1:0] BIT_SAT = CNT_W'(FRAME_BITS + 1);
   localparam logic [3:0] RX_HDR = 4'b1010;
   localparam logic [3:0] TX_HDR = 4'b0101;
   localparam int HDR_LSB = 12;
   localparam int RX_START = 11;
   localparam int RX_LOAD_LSB = 5;
   localparam int RX_RSV_LSB = 1;
   localparam int TX_SHORT = 11;
   localparam int TX_SIGN_LSB = 8;
   localparam int TX_CNT_LSB = 0;
   localparam logic [1:0] LOAD_RESERVED = 2'b11;
   typedef enum logic [1:0] {IDLE, SHIFT, CHECK} link_state_e;
   function automatic logic rx_frame_ok(input logic [FRAME_BITS-1:0] f, input logic [CNT_W-1:0] n);
      logic [5:0] ld;
      ld = f[RX_LOAD_LSB +: 6];
      return n == CNT_W'(FRAME_BITS) && f[HDR_LSB +: 4] == RX_HDR && f[RX_RSV_LSB +: 4] == 4'd0 && !(^f)
         && ld[5:4] != LOAD_RESERVED && ld[3:2] != LOAD_RESERVED && ld[1:0] != LOAD_RESERVED;
   endfunction
endpackage

// File: rtl/mcu_link_slave_if.sv
// mcu_link_slave_if: SPI pins between the MCU master and the link slave
interface mcu_link_slave_if;
   logic sclk;
   logic cs_n;
   logic mosi;
   logic miso;
   modport master (output sclk, output cs_n, output mosi, input miso);
   modport slave (input sclk, input cs_n, input mosi, output miso);
endinterface

// File: rtl/link_sync.sv
// link_sync: N-stage synchronizer with single-cycle rise/fall pulses on the synced level
module link_sync #(
   parameter int N = 2,
   parameter logic RST_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q,
   output logic rise,
   output logic fall
);
   logic [N-1:0] s;
   logic prev;
   always_ff @(posedge clk) begin
      if (rst) begin
         s <= {N{RST_VAL}};
         prev <= RST_VAL;
      end else begin
         s <= {s[N-2:0], d};
         prev <= s[N-1];
      end
   end
   assign q = s[N-1];
   assign rise = q & ~prev;
   assign fall = ~q & prev;
endmodule

// File: rtl/mcu_link_slave.sv
// mcu_link_slave: SPI mode-0 command slave decoding start/load words, returning status, with a silence watchdog
module mcu_link_slave
   import mcu_link_pkg::*;
#(
   parameter int SYNC_STAGES = 2,
   parameter int WDOG_CYCLES = 2500000
) (
   input  logic clk,
   input  logic rst,
   mcu_link_slave_if.slave spi,
   input  logic short,
   input  logic [2:0] current_sign,
   output logic [5:0] desired_load,
   output logic start,
   output logic cmd_valid,
   output logic frame_err,
   output logic wdog_trip
);
   localparam int WW = $clog2(WDOG_CYCLES + 1);
   link_state_e state;
   logic [FRAME_BITS-1:0] rx, tx, snap;
   logic [CNT_W-1:0] bits;
   logic [7:0] frames;
   logic [WW-1:0] wdog;
   logic sclk_rise, sclk_fall, cs_q, cs_rise, cs_fall, mosi_q;
   logic sclk_q_unused, mosi_rise_unused, mosi_fall_unused;
   logic accept, reject, wdog_done;
   link_sync #(.N(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk (
      .clk(clk), .rst(rst), .d(spi.sclk), .q(sclk_q_unused), .rise(sclk_rise), .fall(sclk_fall)
   );
   link_sync #(.N(SYNC_STAGES), .RST_VAL(1'b1)) u_cs (
      .clk(clk), .rst(rst), .d(spi.cs_n), .q(cs_q), .rise(cs_rise), .fall(cs_fall)
   );
   link_sync #(.N(SYNC_STAGES), .RST_VAL(1'b0)) u_mosi (
      .clk(clk), .rst(rst), .d(spi.mosi), .q(mosi_q), .rise(mosi_rise_unused), .fall(mosi_fall_unused)
   );
   always_comb begin
      snap = '0;
      snap[HDR_LSB +: 4] = TX_HDR;
      snap[TX_SHORT] = short;
      snap[TX_SIGN_LSB +: 3] = current_sign;
      snap[TX_CNT_LSB +: 8] = frames;
   end
   assign accept = state == CHECK && rx_frame_ok(rx, bits);
   assign reject = state == CHECK && !accept;
   assign wdog_done = wdog == WW'(WDOG_CYCLES - 1);
   assign spi.miso = tx[FRAME_BITS-1] & ~cs_q;
   // acceptance is checked before the watchdog so a frame landing on expiry still wins
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         rx <= '0;
         tx <= '0;
         bits <= '0;
         frames <= '0;
         wdog <= '0;
         desired_load <= '0;
         start <= 1'b0;
         cmd_valid <= 1'b0;
         frame_err <= 1'b0;
         wdog_trip <= 1'b0;
      end else begin
         state <= state == IDLE ? (cs_fall ? SHIFT : IDLE) : state == SHIFT ? (cs_rise ? CHECK : SHIFT) : IDLE;
         cmd_valid <= accept;
         frame_err <= reject;
         if (state == IDLE && cs_fall) begin
            bits <= '0;
            tx <= snap;
         end
         if (state == SHIFT && sclk_rise) begin
            rx <= {rx[FRAME_BITS-2:0], mosi_q};
            bits <= bits == BIT_SAT ? BIT_SAT : bits + 1'b1;
         end
         if (state == SHIFT && sclk_fall) tx <= {tx[FRAME_BITS-2:0], 1'b0};
         if (accept) begin
            desired_load <= rx[RX_LOAD_LSB +: 6];
            start <= rx[RX_START];
            frames <= frames + 1'b1;
            wdog <= '0;
            wdog_trip <= 1'b0;
         end else if (wdog_done) begin
            desired_load <= '0;
            start <= 1'b0;
            wdog_trip <= 1'b1;
         end else begin
            wdog <= wdog + 1'b1;
         end
      end
   end
endmodule
